// File: rtl/uart_pkg.sv
// Shared UART constants: data width, default receive FIFO depth, capture FSM encoding and baud timing.
package uart_pkg;

   localparam int UART_DW    = 8;
   localparam int FIFO_DEPTH = 16;

   localparam int CLK_HZ     = 50_000_000;
   localparam int BAUD_RATE  = 9600;
   localparam int OVERSAMPLE = 16;
   localparam int BAUD_DIV   = CLK_HZ / BAUD_RATE;
   localparam int TICK_DIV   = CLK_HZ / (BAUD_RATE * OVERSAMPLE);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_WAIT = 2'd2
   } cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular buffer with first-word-fall-through read; full/empty come from the occupancy count.
// A push into a full buffer is accepted only when a pop happens on the same edge.
module sync_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_en_i,
   input  logic [W-1:0]  wr_data_i,
   input  logic          rd_en_i,
   output logic [W-1:0]  rd_data_o,
   output logic          empty_o,
   output logic          full_o,
   output logic [AW:0]   count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          rd_ok, wr_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;

   // A pop on an empty buffer is meaningless; a full buffer only takes a push if it pops too.
   assign rd_ok = rd_en_i && !empty_o;
   assign wr_ok = wr_en_i && (!full_o || rd_ok);

   assign rd_data_o = empty_o ? '0 : mem_q[rptr_q];

   always_comb begin
      wptr_d  = wr_ok ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = rd_ok ? rptr_q + 1'b1 : rptr_q;
      count_d = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_ok) begin
         mem_q[wptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures receiver bytes into a FWFT FIFO, pulses rx_flag_clr once per flag, tracks sticky overflow.
// UART_RX_FIFO_PERR_DROP_EN: discard parity-error bytes and count them on perr_drop_cnt.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DW    = UART_DW,
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic [DW-1:0] rx_data,
   input  logic          rx_flag,
   input  logic          parity_error,
   output logic          rx_flag_clr,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          rd_perr,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          overflow_clr
`ifdef UART_RX_FIFO_PERR_DROP_EN
   ,
   output logic [7:0]    perr_drop_cnt
`endif
);

   cap_state_t  state_q;
   logic        rx_flag_clr_q;
   logic        overflow_q, overflow_d;
   logic        capture, store, overflow_set;
   logic [DW:0] wr_word, rd_word;

   assign capture = (state_q == ST_IDLE) && rx_flag;

`ifdef UART_RX_FIFO_PERR_DROP_EN
   logic [7:0] perr_drop_cnt_q, perr_drop_cnt_d;

   assign store   = capture && !parity_error;
   assign wr_word = {1'b0, rx_data};
   assign rd_perr = 1'b0;
   assign perr_drop_cnt = perr_drop_cnt_q;

   always_comb begin
      perr_drop_cnt_d = perr_drop_cnt_q;
      if (capture && parity_error && perr_drop_cnt_q != 8'hFF) begin
         perr_drop_cnt_d = perr_drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (nrst) perr_drop_cnt_q <= '0;
      else      perr_drop_cnt_q <= perr_drop_cnt_d;
   end
`else
   assign store   = capture;
   assign wr_word = {parity_error, rx_data};
   assign rd_perr = rd_word[DW];
`endif

   sync_fifo #(
      .W     (DW + 1),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk_i     (clk),
      .rst_i     (nrst),
      .wr_en_i   (store),
      .wr_data_i (wr_word),
      .rd_en_i   (rd_en),
      .rd_data_o (rd_word),
      .empty_o   (empty),
      .full_o    (full),
      .count_o   (count)
   );

   assign rd_data     = rd_word[DW-1:0];
   assign rx_flag_clr = rx_flag_clr_q;
   assign overflow    = overflow_q;

   // Full implies non-empty, so a same-cycle rd_en always frees the slot the byte needs.
   assign overflow_set = store && full && !rd_en;

   always_comb begin
      overflow_d = overflow_q;
      if (overflow_set)      overflow_d = 1'b1;
      else if (overflow_clr) overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (nrst) overflow_q <= 1'b0;
      else      overflow_q <= overflow_d;
   end

   always_ff @(posedge clk) begin
      if (nrst) begin
         state_q       <= ST_IDLE;
         rx_flag_clr_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               rx_flag_clr_q <= 1'b0;
               if (rx_flag) begin
                  state_q       <= ST_CLR;
                  rx_flag_clr_q <= 1'b1;
               end
            end
            ST_CLR: begin
               state_q       <= ST_WAIT;
               rx_flag_clr_q <= 1'b0;
            end
            ST_WAIT: begin
               rx_flag_clr_q <= 1'b0;
               if (!rx_flag) state_q <= ST_IDLE;
            end
            default: begin
               state_q       <= ST_IDLE;
               rx_flag_clr_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a simple receiver model hands bytes over and host pops are checked.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       nrst = 1'b1;
   logic [7:0] rx_data = '0;
   logic       rx_flag = 1'b0;
   logic       parity_error = 1'b0;
   logic       rx_flag_clr;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_perr;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overflow;
   logic       overflow_clr = 1'b0;
`ifdef UART_RX_FIFO_PERR_DROP_EN
   logic [7:0] perr_drop_cnt;
`endif

   int errors = 0;
   int checks = 0;
   int pulses;

   always #10 clk = ~clk;

   uart_rx_fifo dut (
      .clk          (clk),
      .nrst         (nrst),
      .rx_data      (rx_data),
      .rx_flag      (rx_flag),
      .parity_error (parity_error),
      .rx_flag_clr  (rx_flag_clr),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_perr      (rd_perr),
      .empty        (empty),
      .full         (full),
      .count        (count),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
`ifdef UART_RX_FIFO_PERR_DROP_EN
      ,
      .perr_drop_cnt(perr_drop_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Receiver model: raise rx_flag, wait (bounded) for the clear pulse, optionally keep the
   // flag up for 'hold' more cycles, then drop it and let the FSM return to IDLE.
   task automatic send(input logic [7:0] d, input logic pe, input int hold, output int np);
      bit seen;
      seen = 0;
      np = 0;
      rx_data = d;
      parity_error = pe;
      rx_flag = 1'b1;
      for (int i = 0; i < 8 && !seen; i++) begin
         tick();
         if (rx_flag_clr) begin
            seen = 1;
            np++;
         end
      end
      chk("clr_seen", 32'(seen), 32'd1);
      for (int i = 0; i < hold; i++) begin
         tick();
         if (rx_flag_clr) np++;
      end
      rx_flag = 1'b0;
      parity_error = 1'b0;
      repeat (2) begin
         tick();
         if (rx_flag_clr) np++;
      end
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      // Reset
      nrst = 1'b1;
      repeat (2) tick();
      nrst = 1'b0;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_clr", 32'(rx_flag_clr), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_rd_perr", 32'(rd_perr), 32'd0);

      // First byte, seen at N+1, with a slow receiver holding the flag 20 more cycles
      send(8'hA5, 1'b0, 20, pulses);
      chk("a5_pulses", 32'(pulses), 32'd1);
      chk("a5_count", 32'(count), 32'd1);
      chk("a5_empty", 32'(empty), 32'd0);
      chk("a5_data", 32'(rd_data), 32'hA5);
      chk("a5_perr", 32'(rd_perr), 32'd0);
      pop();
      chk("a5_pop_empty", 32'(empty), 32'd1);

      // rd_en while empty is ignored
      pop();
      chk("uflow_count", 32'(count), 32'd0);

      // Write and read together while empty: only the write lands
      rx_data = 8'h6B;
      rx_flag = 1'b1;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("wr_rd_empty_clr", 32'(rx_flag_clr), 32'd1);
      chk("wr_rd_empty_count", 32'(count), 32'd1);
      chk("wr_rd_empty_data", 32'(rd_data), 32'h6B);
      rx_flag = 1'b0;
      repeat (2) tick();
      pop();
      chk("wr_rd_empty_drain", 32'(empty), 32'd1);

      // Fill to 16, then overflow with a 17th byte
      for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 0, pulses);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd16);
      chk("fill_ovf", 32'(overflow), 32'd0);
      send(8'hFF, 1'b0, 0, pulses);
      chk("ovf_pulses", 32'(pulses), 32'd1);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd16);
      chk("ovf_full", 32'(full), 32'd1);
      for (int i = 0; i < 16; i++) begin
         chk("drain_data", 32'(rd_data), 32'(i));
         pop();
      end
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_ovf_sticky", 32'(overflow), 32'd1);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // Full FIFO with a same-cycle pop: capture accepted, no overflow
      for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0, 0, pulses);
      rx_data = 8'h55;
      rx_flag = 1'b1;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("fullrd_clr", 32'(rx_flag_clr), 32'd1);
      rx_flag = 1'b0;
      repeat (2) tick();
      chk("fullrd_ovf", 32'(overflow), 32'd0);
      chk("fullrd_count", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++) begin
         chk("fullrd_data", 32'(rd_data), (i < 15) ? 32'h11 + 32'(i) : 32'h55);
         pop();
      end
      chk("fullrd_empty", 32'(empty), 32'd1);

      // Parity-error byte
      send(8'h3C, 1'b1, 0, pulses);
      chk("perr_pulses", 32'(pulses), 32'd1);
`ifdef UART_RX_FIFO_PERR_DROP_EN
      chk("perr_drop_count", 32'(count), 32'd0);
      chk("perr_drop_cnt", 32'(perr_drop_cnt), 32'd1);
`else
      chk("perr_count", 32'(count), 32'd1);
      chk("perr_data", 32'(rd_data), 32'h3C);
      chk("perr_bit", 32'(rd_perr), 32'd1);
      pop();
`endif

      // Reset while in WAIT with entries stored; the still-high flag is captured again
      for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), 1'b0, 0, pulses);
      chk("pre_rst_count", 32'(count), 32'd5);
      rx_data = 8'h77;
      rx_flag = 1'b1;
      tick();
      chk("pre_rst_clr", 32'(rx_flag_clr), 32'd1);
      tick();
      nrst = 1'b1;
      tick();
      nrst = 1'b0;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_empty", 32'(empty), 32'd1);
      chk("mid_rst_clr", 32'(rx_flag_clr), 32'd0);
      tick();
      chk("recap_clr", 32'(rx_flag_clr), 32'd1);
      chk("recap_count", 32'(count), 32'd1);
      chk("recap_data", 32'(rd_data), 32'h77);
      rx_flag = 1'b0;
      repeat (2) tick();
      pop();
      chk("final_empty", 32'(empty), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Detects the receiver's rx_flag, captures the 8-bit byte and its parity_error, and pulses rx_flag_clr back to the receiver.
- Stores byte plus error bit in a circular FIFO and presents a first-word-fall-through read interface to the host/register logic.
- Frees the consumer from servicing each byte within one frame time (~1.04 ms at 9600 baud).

Parameters:
- DW, 8, data width per entry; the stored word is DW+1 bits: {perr, data}.
- DEPTH, 16, number of entries; must be a power of two.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  system clock (50 MHz)
- nrst  in  1  synchronous, active-high reset; one clock, all state sampled on the rising edge of clk
- rx_data  in  DW  byte from the receiver, stable while rx_flag=1
- rx_flag  in  1  receiver byte-ready level; held until cleared
- parity_error  in  1  receiver parity result for rx_data
- rx_flag_clr  out  1  one-cycle pulse that clears the receiver's rx_flag
- rd_en  in  1  pop head entry
- rd_data  out  DW  head entry data
- rd_perr  out  1  head entry parity-error bit
- empty  out  1  FIFO holds 0 entries
- full  out  1  FIFO holds DEPTH entries
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a byte was dropped because the FIFO was full
- overflow_clr  in  1  clears overflow

Behaviour:
- Reset (nrst=1 at an edge):
  - Pointers = 0, count = 0, empty = 1, full = 0.
  - overflow = 0, rx_flag_clr = 0, FSM = IDLE.
  - rd_data and rd_perr = 0 while empty.
  - Memory contents are not cleared.
  - Reset mid-capture abandons the byte; the receiver's rx_flag stays set and is captured again after reset.
- Capture FSM, three states:
  - IDLE: if rx_flag=1, write {parity_error, rx_data} unless full, set rx_flag_clr=1 for the next cycle, and go to CLR.
  - CLR: rx_flag_clr=1 for exactly this one cycle; go to WAIT.
  - WAIT: stay until rx_flag=0, then go to IDLE. This guarantees exactly one write per flag assertion.
- Write latency: write occurs on the edge where IDLE sees rx_flag=1 (cycle N). empty falls and rd_data/rd_perr are valid at N+1.
- Full at capture:
  - The byte is dropped and overflow is set at N+1.
  - rx_flag_clr is still pulsed.
  - Exception: rd_en in the same cycle frees a slot first, so the write is accepted; count is unchanged and overflow stays 0.
- Read:
  - rd_data and rd_perr always show the head entry (FWFT).
  - rd_en=1 with empty=0 advances the read pointer and decrements count on that edge; the next entry is visible the following cycle.
  - rd_en while empty is ignored: no pointer move, no underflow flag.
- Simultaneous write and read with non-empty FIFO: both pointers advance and count is unchanged.
- Simultaneous write and read with empty FIFO: only the write takes effect. The rd_en is ignored because FWFT data is not yet valid.
- Pointers are AW bits and wrap modulo DEPTH. full/empty are derived from count (AW+1 bits), never from pointer equality alone.
- overflow_clr has priority below a same-cycle overflow set, so set wins.

Optional Feature:
- Macro: UART_RX_FIFO_PERR_DROP_EN.
- Defined:
  - Bytes with parity_error=1 are not written.
  - rx_flag_clr is still pulsed.
  - An extra output perr_drop_cnt [7:0] counts discarded bytes, saturates at 255, and resets to 0.
  - rd_perr is tied to 0.
- Undefined: every byte is stored with its error bit; the perr_drop_cnt port does not exist.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DW = 8
  - FIFO depth default
  - capture FSM state encoding (IDLE=2'd0, CLR=2'd1, WAIT=2'd2)
  - baud constants shared with the Tx/Rx blocks
- Natural sub-module: sync_fifo, a parameterised circular buffer with pointers, count, full/empty and FWFT read.
- uart_rx_fifo contains only the capture FSM, the overflow logic and the optional drop counter.

Test Plan:
- Reset, then rx_flag=1 with rx_data=8'hA5 and parity_error=0, held until rx_flag_clr → one rx_flag_clr pulse; at N+1 empty=0, count=1, rd_data=A5, rd_perr=0.
- Hold rx_flag=1 for 20 cycles after the clr pulse (slow receiver) → exactly one entry written, count=1.
- Write 16 bytes 8'h00..8'h0F, then a 17th byte 8'hFF → full=1, overflow=1, count=16. Pop 16 times → data 00..0F in order, then empty=1. Pulse overflow_clr → overflow=0.
- FIFO full with 16 entries; capture 8'h55 with rd_en=1 in the same cycle → overflow=0, count=16, 55 is the last entry read.
- Byte 8'h3C with parity_error=1 → rd_perr=1 with rd_data=3C. With UART_RX_FIFO_PERR_DROP_EN defined → count=0 and perr_drop_cnt=1.
- Assert nrst mid-WAIT with 5 entries stored → count=0, empty=1, FSM=IDLE; a still-high rx_flag is recaptured and count=1.
